// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, types and helpers for the 8x8 matrix scanner.
// Define MATRIX_BLANKING_EN to add the all-rows-off BLANK state before each row.
package matrix_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int ROW_IDX_W   = $clog2(MATRIX_ROWS);

  typedef logic [MATRIX_COLS-1:0] row_t;
  typedef logic [ROW_IDX_W-1:0]   row_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef MATRIX_BLANKING_EN
    ST_BLANK = 2'd1,
`endif
    ST_DRIVE = 2'd2
  } scan_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic row_t row_onehot(input row_idx_t idx);
    return row_t'(1) << idx;
  endfunction

endpackage

// File: rtl/matrix_frame_buf.sv
// matrix_frame_buf: two-bank 8x8 frame store; writes go to the back bank,
// reads come from the front bank, swap_i toggles which bank is front.
// Ports: clk_i, rst_i, wr_en_i/wr_row_i/wr_data_i (back-bank write),
//        swap_i (bank toggle), rd_row_i/rd_data_o (front-bank read).
module matrix_frame_buf
  import matrix_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     wr_en_i,
  input  row_idx_t wr_row_i,
  input  row_t     wr_data_i,
  input  logic     swap_i,
  input  row_idx_t rd_row_i,
  output row_t     rd_data_o
);

  row_t mem_q [2][MATRIX_ROWS];
  logic front_q;
  logic rd_bank;

  // Read looks through a swap happening this cycle, so a row latched at
  // the swap edge already comes from the new front bank.
  assign rd_bank = front_q ^ swap_i;

  always_comb begin
    rd_data_o = mem_q[rd_bank][rd_row_i];
    // A write landing in the soon-to-be front bank this cycle is forwarded.
    if (swap_i && wr_en_i && (wr_row_i == rd_row_i)) begin
      rd_data_o = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      front_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < MATRIX_ROWS; r++) begin
          mem_q[b][r] <= '0;
        end
      end
    end else begin
      if (wr_en_i) begin
        mem_q[~front_q][wr_row_i] <= wr_data_i;
      end
      if (swap_i) begin
        front_q <= ~front_q;
      end
    end
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: row-scan controller for an 8x8 LED matrix with a
// double-buffered frame store and frame-boundary bank swap.
// Ports: clk_i, rst_i (sync, active-high), en_i, wr_en_i, wr_row_i,
//   wr_data_i, swap_req_i -> swap_ack_o, row_sel_o, col_data_o,
//   row_idx_o, frame_done_o.
// Macro MATRIX_BLANKING_EN: insert BLANK_CYCLES of all-off before each row.
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       wr_en_i,
  input  logic [2:0] wr_row_i,
  input  logic [7:0] wr_data_i,
  input  logic       swap_req_i,
  output logic       swap_ack_o,
  output logic [7:0] row_sel_o,
  output logic [7:0] col_data_o,
  output logic [2:0] row_idx_o,
  output logic       frame_done_o
);

  localparam int CNT_MAX = max_int(DWELL_CYCLES, BLANK_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
`ifdef MATRIX_BLANKING_EN
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
`endif

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  row_idx_t         row_q, row_d;
  row_t             row_sel_q, row_sel_d;
  row_t             col_q, col_d;
  logic             fd_q, fd_d;
  logic             pend_q, pend_d;

  row_idx_t rd_row;
  row_t     rd_data;
  logic     swap_pt;
  logic     swap_take;
  logic     cnt_zero;

  // Row whose data will be latched when the next DRIVE is entered.
`ifdef MATRIX_BLANKING_EN
  assign rd_row = row_q;
`else
  assign rd_row = (state_q == ST_DRIVE) ? row_q + row_idx_t'(1) : '0;
`endif

  // fd_q marks the last dwell cycle of row 7; idle is always a swap point.
  assign swap_pt   = (state_q == ST_IDLE) | fd_q;
  assign swap_take = ~rst_i & swap_pt & (pend_q | swap_req_i);
  assign cnt_zero  = (cnt_q == '0);

  matrix_frame_buf u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en_i),
    .wr_row_i  (wr_row_i),
    .wr_data_i (wr_data_i),
    .swap_i    (swap_take),
    .rd_row_i  (rd_row),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    row_sel_d = row_sel_q;
    col_d     = col_q;
    pend_d    = swap_take ? 1'b0 : (pend_q | swap_req_i);

    if (!en_i) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      row_d     = '0;
      row_sel_d = '0;
      col_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          row_d = '0;
`ifdef MATRIX_BLANKING_EN
          state_d   = ST_BLANK;
          cnt_d     = BLANK_LD;
          row_sel_d = '0;
          col_d     = '0;
`else
          state_d   = ST_DRIVE;
          cnt_d     = DWELL_LD;
          row_sel_d = row_onehot(rd_row);
          col_d     = rd_data;
`endif
        end
`ifdef MATRIX_BLANKING_EN
        ST_BLANK: begin
          if (cnt_zero) begin
            state_d   = ST_DRIVE;
            cnt_d     = DWELL_LD;
            row_sel_d = row_onehot(rd_row);
            col_d     = rd_data;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`endif
        ST_DRIVE: begin
          if (cnt_zero) begin
            row_d = row_q + row_idx_t'(1);
`ifdef MATRIX_BLANKING_EN
            state_d   = ST_BLANK;
            cnt_d     = BLANK_LD;
            row_sel_d = '0;
            col_d     = '0;
`else
            state_d   = ST_DRIVE;
            cnt_d     = DWELL_LD;
            row_sel_d = row_onehot(rd_row);
            col_d     = rd_data;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          row_d     = '0;
          row_sel_d = '0;
          col_d     = '0;
        end
      endcase
    end

    // Registered pulse: high exactly during row 7's final dwell cycle.
    fd_d = (state_d == ST_DRIVE) && (row_d == row_idx_t'(MATRIX_ROWS - 1))
           && (cnt_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      row_sel_q <= '0;
      col_q     <= '0;
      fd_q      <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
      fd_q      <= fd_d;
      pend_q    <= pend_d;
    end
  end

  assign swap_ack_o   = swap_take;
  assign row_sel_o    = row_sel_q;
  assign col_data_o   = col_q;
  assign row_idx_o    = row_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl: directed scoreboard bench for matrix_scan_ctrl
// (DWELL_CYCLES=4, BLANK_CYCLES=2; follows MATRIX_BLANKING_EN if defined).
module tb_matrix_scan_ctrl;

  localparam int DW = 4;
`ifdef MATRIX_BLANKING_EN
  localparam int BLK = 2;
`else
  localparam int BLK = 0;
`endif
  localparam int S  = BLK + DW;
  localparam int P  = 8 * S;
  localparam int D0 = 1 + BLK;

  logic       clk = 1'b0;
  logic       rst, en, wr_en, swap_req;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_ack, frame_done;
  logic [7:0] row_sel, col_data;
  logic [2:0] row_idx;

  matrix_scan_ctrl #(
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .wr_en_i      (wr_en),
    .wr_row_i     (wr_row),
    .wr_data_i    (wr_data),
    .swap_req_i   (swap_req),
    .swap_ack_o   (swap_ack),
    .row_sel_o    (row_sel),
    .col_data_o   (col_data),
    .row_idx_o    (row_idx),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic [7:0] rs;
    logic [7:0] cd;
    logic [2:0] ri;
    logic       fd;
    logic       ack;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_ack = 0;
  int   n_fd = 0;
  int   ntag = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [7:0] rs, input logic [7:0] cd,
                      input logic [2:0] ri, input logic fd, input logic ack);
    exp_t e;
    ntag++;
    e.cyc = c; e.rs = rs; e.cd = cd; e.ri = ri;
    e.fd = fd; e.ack = ack; e.tag = ntag;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the expectation due this cycle and compares.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL vec%0d: cycle %0d not sampled (now %0d)", e.tag, e.cyc, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({row_sel, col_data, row_idx, frame_done, swap_ack} !==
          {e.rs, e.cd, e.ri, e.fd, e.ack}) begin
        n_bad++;
        $display("FAIL vec%0d @%0d: got rs=%h cd=%h idx=%0d fd=%b ack=%b, want rs=%h cd=%h idx=%0d fd=%b ack=%b",
                 e.tag, cyc, row_sel, col_data, row_idx, frame_done, swap_ack,
                 e.rs, e.cd, e.ri, e.fd, e.ack);
      end
    end
    if (swap_ack === 1'b1) n_ack++;
    if (frame_done === 1'b1) n_fd++;
  end

  initial begin
    int r, r1, r2, c3, c5, t;
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    wr_row = '0; wr_data = '0;
    goto(2);
    rst = 1'b0; en = 1'b1;
    r = 2;

    // Frame 1: start-up timing, back-bank writes invisible, swap at boundary.
    push(r, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
`ifdef MATRIX_BLANKING_EN
    push(r + 1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    push(r + D0 + DW, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0);
`else
    push(r + D0 + DW, 8'h02, 8'h00, 3'd1, 1'b0, 1'b0);
`endif
    push(r + D0, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    push(r + D0 + 3, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    exp_q.sort() with (item.cyc);
    push(r + P, 8'h80, 8'h00, 3'd7, 1'b1, 1'b1);
    for (int n = 0; n < 8; n++) begin
      goto(r + 2 + n);
      wr_en = 1'b1; wr_row = 3'(n); wr_data = 8'h01 << n;
    end
    goto(r + 10); wr_en = 1'b0;
    goto(r + 12); swap_req = 1'b1;
    goto(r + 13); swap_req = 1'b0;

    // Frame 2: new data visible; two requests while pending.
    goto(r + P + 1);
    push(r + P + D0, 8'h01, 8'h01, 3'd0, 1'b0, 1'b0);
    push(r + P + D0 + 2 * S, 8'h04, 8'h04, 3'd2, 1'b0, 1'b0);
    push(r + 2 * P, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1);
    goto(r + P + 2);
    wr_en = 1'b1; wr_row = 3'd2; wr_data = 8'hA5;
    goto(r + P + 3); wr_en = 1'b0;
    goto(r + P + 5); swap_req = 1'b1;
    goto(r + P + 6); swap_req = 1'b0;
    goto(r + P + 8); swap_req = 1'b1;
    goto(r + P + 9); swap_req = 1'b0;

    // Frame 3: sparse bank; request exactly in the frame_done cycle.
    goto(r + 2 * P + 1);
    push(r + 2 * P + D0, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    push(r + 2 * P + D0 + 2 * S, 8'h04, 8'hA5, 3'd2, 1'b0, 1'b0);
    push(r + 3 * P, 8'h80, 8'h00, 3'd7, 1'b1, 1'b1);
    goto(r + 3 * P); swap_req = 1'b1;
    goto(r + 3 * P + 1); swap_req = 1'b0;

    // Frame 4: drop enable during row 3, then restart.
    c3 = r + 3 * P + D0 + 3 * S;
    push(c3, 8'h08, 8'h08, 3'd3, 1'b0, 1'b0);
    push(c3 + 2, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    goto(c3 + 1); en = 1'b0;
    goto(c3 + 2); en = 1'b1;
    r1 = c3 + 2;
    push(r1 + D0, 8'h01, 8'h01, 3'd0, 1'b0, 1'b0);
    push(r1 + P, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0);

    // Next frame: reset in row 5 with a swap pending.
    goto(r1 + P + 1);
    c5 = r1 + P + D0 + 5 * S;
    push(c5, 8'h20, 8'h20, 3'd5, 1'b0, 1'b0);
    push(c5 + 2, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    goto(r1 + P + 3); swap_req = 1'b1;
    goto(r1 + P + 4); swap_req = 1'b0;
    goto(c5 + 1); rst = 1'b1;
    goto(c5 + 2); rst = 1'b0;
    r2 = c5 + 2;
    push(r2 + D0, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    push(r2 + D0 + S, 8'h02, 8'h00, 3'd1, 1'b0, 1'b0);
    push(r2 + P, 8'h80, 8'h00, 3'd7, 1'b1, 1'b0);
    goto(r2 + P + 2);

    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL vec%0d: never checked (cycle %0d)", e.tag, e.cyc);
    end
    n_vec++;
    if (n_ack != 3) begin
      n_bad++;
      $display("FAIL ack_count: got %0d, want 3", n_ack);
    end
    n_vec++;
    if (n_fd != 5) begin
      n_bad++;
      $display("FAIL fd_count: got %0d, want 5", n_fd);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 1000, clock cycles each row is driven (legal range >= 1).
REQ-002 Parameter BLANK_CYCLES, default 4, clock cycles all rows are off between rows (legal range >= 1; used only with MATRIX_BLANKING_EN).
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 en  in  1  scan enable (level).
REQ-006 wr_en  in  1  write strobe: one row of the back bank per cycle.
REQ-007 wr_row  in  3  back-bank row index for the write.
REQ-008 wr_data  in  8  column pattern for the write (bit n = column n).
REQ-009 swap_req  in  1  request a front/back bank swap at the next frame boundary.
REQ-010 swap_ack  out  1  one-cycle pulse in the cycle the swap takes effect.
REQ-011 row_sel  out  8  one-hot row drive; all zero when blanked or idle.
REQ-012 col_data  out  8  column pattern of the driven row; zero when blanked or idle.
REQ-013 row_idx  out  3  index of the current row.
REQ-014 frame_done  out  1  one-cycle pulse when row 7's dwell completes.

Function
REQ-015 States IDLE, BLANK, DRIVE; one down-counter of width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1) times each state.
REQ-016 IDLE: row_sel=0, col_data=0, row_idx=0; when en=1, next state is BLANK (macro on) or DRIVE (macro off) with row_idx=0.
REQ-017 BLANK: row_sel=0 and col_data=0 for exactly BLANK_CYCLES cycles, then DRIVE.
REQ-018 DRIVE: row_sel=1<<row_idx and col_data=front[row_idx], held for exactly DWELL_CYCLES cycles; outputs are registered and change on the cycle the state is entered.
REQ-019 End of DRIVE: row_idx increments; 7 wraps to 0; next state is BLANK (macro on) or DRIVE of the next row (macro off).
REQ-020 End of DRIVE for row 7: frame_done=1 for that one cycle.
REQ-021 Frame period: 8*(BLANK_CYCLES+DWELL_CYCLES) cycles with the macro on, 8*DWELL_CYCLES with it off.
REQ-022 en=0 in any state: IDLE on the next cycle; counter and row_idx clear; no frame_done pulse.
REQ-023 swap_req=1 sets a pending flag; further requests while pending have no effect.
REQ-024 Swap point: the frame boundary (REQ-020 cycle), or the next cycle when in IDLE.
REQ-025 At the swap point, if pending or swap_req=1 that cycle: front/back toggle, swap_ack pulses one cycle, pending clears.
REQ-026 wr_en=1 writes wr_data into back[wr_row] at the next edge; the data never appears on col_data before a swap.
REQ-027 A write in the swap cycle targets the pre-swap back bank, so it lands in the new front bank.
REQ-028 Simultaneous swap_req and swap point: swap taken that cycle; pending is not left set.

Reset
REQ-029 rst=1 at the clock edge: state IDLE, counter 0, row_idx 0, row_sel 0, col_data 0, frame_done 0, swap_ack 0, pending 0, front=bank 0, both banks all-zero.
REQ-030 rst overrides en, wr_en and swap_req in the same cycle.
REQ-031 Reset mid-frame abandons the frame with no frame_done or swap_ack pulse.

Configuration
REQ-032 Macro MATRIX_BLANKING_EN defined: the BLANK state precedes every DRIVE (anti-ghosting).
REQ-033 Macro undefined: BLANK state, its counter compare and BLANK_CYCLES are compiled out, and rows are driven back-to-back.

Structure
REQ-034 Package matrix_pkg holds MATRIX_ROWS=8, MATRIX_COLS=8, the row_t (8-bit) typedef and the scan-state enum typedef.
REQ-035 Sub-module matrix_frame_buf holds the two-bank 8x8 register file (write port to back, read port from front, bank-select toggle).

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2, macro on unless stated)
REQ-036 Reset, then en=1 -> 2 cycles with row_sel=00000000, then row_sel=00000001 with col_data=00 for 4 cycles; frame_done pulses every 48 cycles.
REQ-037 Write rows 0..7 = 8'h01..8'h80, then swap_req -> col_data stays 00 until swap_ack at the frame boundary; the next frame shows row n = 1<<n.
REQ-038 Second swap_req while pending -> exactly one swap_ack; swap_req in the frame_done cycle -> swap_ack in that same cycle.
REQ-039 en=0 during DRIVE row 3 -> IDLE next cycle, outputs 0; en=1 restarts at row 0.
REQ-040 rst=1 in DRIVE row 5 with a swap pending -> all outputs 0 next cycle, no swap_ack, col_data 00 after restart.
REQ-041 Macro undefined -> row_sel never 0 during a scan; frame_done period 32 cycles.
